// File: rtl/secuenciador_pkg.sv
// rtl/secuenciador_pkg.sv - opcode encoding shared by the microprogram sequencer
package secuenciador_pkg;

  typedef enum logic [2:0] {
    OP_CONT  = 3'b000,
    OP_SALTO = 3'b001,
    OP_MAPA  = 3'b010,
    OP_VECT  = 3'b011,
    OP_LLAMA = 3'b100,
    OP_RET   = 3'b101,
    OP_CARGA = 3'b110,
    OP_CICLO = 3'b111
  } opcode_e;

endpackage

// File: rtl/pila_lifo.sv
// rtl/pila_lifo.sv - return-address LIFO; pointer counts held entries, contents unreset
module pila_lifo #(
  parameter int ANCHO = 4,
  parameter int PROF  = 4
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [ANCHO-1:0] dato,
  output logic [ANCHO-1:0] tope,
  output logic             llena,
  output logic             vacia
);

  localparam int PW = $clog2(PROF + 1);
  localparam int IW = $clog2(PROF);

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [ANCHO-1:0] mem_q [PROF];

  assign llena = (ptr_q == PW'(PROF));
  assign vacia = (ptr_q == '0);
  assign tope  = mem_q[IW'(ptr_q - PW'(1))];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !llena) begin
      ptr_d = ptr_q + PW'(1);
    end else if (pop && !vacia) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge reloj) begin
    if (push && !llena) begin
      mem_q[IW'(ptr_q)] <= dato;
    end
  end

endmodule

// File: rtl/secuenciador_pila.sv
// rtl/secuenciador_pila.sv - microprogram sequencer with call stack; SECUENCIADOR_CONTADOR_EN adds loop counter
module secuenciador_pila
  import secuenciador_pkg::*;
#(
  parameter int ANCHO = 4,
  parameter int PROF  = 4
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             cc,
  input  logic [2:0]       microinstruccion,
  input  logic [ANCHO-1:0] liga,
  input  logic [ANCHO-1:0] vect,
  input  logic [ANCHO-1:0] vmap,
  output logic             pl,
  output logic             map_hab,
  output logic             vect_hab,
  output logic [ANCHO-1:0] estado_presente,
  output logic             pila_llena,
  output logic             pila_vacia,
  output logic             error_pila
);

  logic [ANCHO-1:0] estado_q, estado_d;
  logic             pl_q, pl_d, map_hab_q, map_hab_d, vect_hab_q, vect_hab_d;
  logic             error_q, error_d;
  logic             push, pop;
  logic [ANCHO-1:0] sig, tope;
  logic             cond;
`ifdef SECUENCIADOR_CONTADOR_EN
  logic [ANCHO-1:0] contador_q, contador_d;
`endif

  assign sig  = estado_q + ANCHO'(1);
  assign cond = ~cc;

  pila_lifo #(.ANCHO(ANCHO), .PROF(PROF)) u_pila (
    .reloj (reloj),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .dato  (sig),
    .tope  (tope),
    .llena (pila_llena),
    .vacia (pila_vacia)
  );

  // Every branch that is not taken falls back to continue via the defaults.
  always_comb begin
    estado_d   = sig;
    pl_d       = 1'b1;
    map_hab_d  = 1'b1;
    vect_hab_d = 1'b1;
    error_d    = error_q;
    push       = 1'b0;
    pop        = 1'b0;
`ifdef SECUENCIADOR_CONTADOR_EN
    contador_d = contador_q;
`endif
    case (opcode_e'(microinstruccion))
      OP_SALTO: if (cond) begin
        estado_d = liga;
        pl_d     = 1'b0;
      end
      OP_MAPA: begin
        estado_d  = vmap;
        map_hab_d = 1'b0;
      end
      OP_VECT: if (cond) begin
        estado_d   = vect;
        vect_hab_d = 1'b0;
      end
      OP_LLAMA: if (cond) begin
        if (pila_llena) begin
          error_d = 1'b1;
        end else begin
          push     = 1'b1;
          estado_d = liga;
          pl_d     = 1'b0;
        end
      end
      OP_RET: begin
        if (pila_vacia) begin
          error_d = 1'b1;
        end else begin
          pop      = 1'b1;
          estado_d = tope;
        end
      end
`ifdef SECUENCIADOR_CONTADOR_EN
      OP_CARGA: contador_d = liga;
      OP_CICLO: if (contador_q != '0) begin
        contador_d = contador_q - ANCHO'(1);
        estado_d   = liga;
        pl_d       = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q   <= '0;
      pl_q       <= 1'b1;
      map_hab_q  <= 1'b1;
      vect_hab_q <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      pl_q       <= pl_d;
      map_hab_q  <= map_hab_d;
      vect_hab_q <= vect_hab_d;
      error_q    <= error_d;
    end
  end

`ifdef SECUENCIADOR_CONTADOR_EN
  always_ff @(posedge reloj) begin
    if (reset) begin
      contador_q <= '0;
    end else begin
      contador_q <= contador_d;
    end
  end
`endif

  assign estado_presente = estado_q;
  assign pl              = pl_q;
  assign map_hab         = map_hab_q;
  assign vect_hab        = vect_hab_q;
  assign error_pila      = error_q;

endmodule

// File: tb/tb_secuenciador_pila.sv
// tb/tb_secuenciador_pila.sv - directed and random checks of secuenciador_pila against a queue-based model
module tb_secuenciador_pila;

  localparam int ANCHO = 4;
  localparam int PROF  = 4;
  localparam int MODV  = 1 << ANCHO;

  logic             reloj = 1'b0;
  logic             reset = 1'b1;
  logic             cc = 1'b1;
  logic [2:0]       microinstruccion = 3'b000;
  logic [ANCHO-1:0] liga = '0, vect = '0, vmap = '0;
  logic             pl, map_hab, vect_hab, pila_llena, pila_vacia, error_pila;
  logic [ANCHO-1:0] estado_presente;

  int checks = 0;
  int failures = 0;

  int m_est = 0;
  int m_cnt = 0;
  int m_stk[$];
  bit m_pl = 1, m_map = 1, m_vect = 1, m_err = 0;

  secuenciador_pila #(.ANCHO(ANCHO), .PROF(PROF)) dut (
    .reloj            (reloj),
    .reset            (reset),
    .cc               (cc),
    .microinstruccion (microinstruccion),
    .liga             (liga),
    .vect             (vect),
    .vmap             (vmap),
    .pl               (pl),
    .map_hab          (map_hab),
    .vect_hab         (vect_hab),
    .estado_presente  (estado_presente),
    .pila_llena       (pila_llena),
    .pila_vacia       (pila_vacia),
    .error_pila       (error_pila)
  );

  always #5 reloj = ~reloj;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model advances from the rules for one edge; then DUT state is compared.
  task automatic step(input int op, input bit c, input int l, input int v,
                      input int m, input bit r);
    int s;
    reset = r; microinstruccion = 3'(op); cc = c;
    liga = ANCHO'(l); vect = ANCHO'(v); vmap = ANCHO'(m);
    if (r) begin
      m_est = 0; m_pl = 1; m_map = 1; m_vect = 1;
      m_stk.delete(); m_cnt = 0; m_err = 0;
    end else begin
      s = (m_est + 1) % MODV;
      m_est = s; m_pl = 1; m_map = 1; m_vect = 1;
      case (op)
        1: if (!c) begin m_est = l; m_pl = 0; end
        2: begin m_est = m; m_map = 0; end
        3: if (!c) begin m_est = v; m_vect = 0; end
        4: if (!c) begin
          if (m_stk.size() >= PROF) m_err = 1;
          else begin m_stk.push_back(s); m_est = l; m_pl = 0; end
        end
        5: if (m_stk.size() == 0) m_err = 1;
           else m_est = m_stk.pop_back();
`ifdef SECUENCIADOR_CONTADOR_EN
        6: m_cnt = l;
        7: if (m_cnt != 0) begin m_cnt--; m_est = l; m_pl = 0; end
`endif
        default: ;
      endcase
    end
    @(posedge reloj);
    #1;
    chk("estado", int'(estado_presente), m_est);
    chk("pl", int'(pl), int'(m_pl));
    chk("map_hab", int'(map_hab), int'(m_map));
    chk("vect_hab", int'(vect_hab), int'(m_vect));
    chk("pila_llena", int'(pila_llena), int'(m_stk.size() == PROF));
    chk("pila_vacia", int'(pila_vacia), int'(m_stk.size() == 0));
    chk("error_pila", int'(error_pila), int'(m_err));
  endtask

  task automatic rst();
    step(0, 1, 0, 0, 0, 1);
  endtask

  initial begin
    rst();
    chk("reset_estado", int'(estado_presente), 0);
    chk("reset_enables", int'({pl, map_hab, vect_hab}), 7);

    for (int i = 0; i < 17; i++) begin
      step(0, $urandom_range(1), $urandom_range(15), 0, 0, 0);
      chk("cont_seq", int'(estado_presente), (i + 1) % 16);
    end

    rst();
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(1, 0, 9, 0, 0, 0);
    chk("jump_taken", int'(estado_presente), 9);
    chk("jump_pl", int'(pl), 0);
    rst();
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0);
    chk("jump_not_taken", int'(estado_presente), 4);

    rst();
    repeat (2) step(0, 1, 0, 0, 0, 0);
    step(4, 0, 8, 0, 0, 0);
    chk("call_target", int'(estado_presente), 8);
    chk("call_vacia", int'(pila_vacia), 0);
    step(5, 1, 0, 0, 0, 0);
    chk("ret_target", int'(estado_presente), 3);
    chk("ret_vacia", int'(pila_vacia), 1);

    rst();
    for (int i = 1; i <= 5; i++) begin
      step(4, 0, 4 * i - 2, 0, 0, 0);
      if (i == 4) chk("full_after_4", int'(pila_llena), 1);
    end
    chk("overflow_err", int'(error_pila), 1);
    chk("overflow_continue", int'(estado_presente), 15);
    rst();
    chk("err_cleared", int'(error_pila), 0);

    step(5, 0, 7, 0, 0, 0);
    chk("underflow_next", int'(estado_presente), 1);
    chk("underflow_err", int'(error_pila), 1);

    rst();
    step(6, 1, 2, 0, 0, 0);
    step(7, 1, 5, 0, 0, 0);
`ifdef SECUENCIADOR_CONTADOR_EN
    chk("loop1", int'(estado_presente), 5);
    step(7, 1, 5, 0, 0, 0);
    chk("loop2", int'(estado_presente), 5);
    step(7, 1, 5, 0, 0, 0);
    chk("loop_exit", int'(estado_presente), 6);
`else
    chk("loop_off1", int'(estado_presente), 2);
    step(7, 1, 5, 0, 0, 0);
    chk("loop_off2", int'(estado_presente), 3);
`endif

    rst();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(7), $urandom_range(1), $urandom_range(15),
           $urandom_range(15), $urandom_range(15), ($urandom_range(59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secuenciador_pila.md
SECUENCIADOR_PILA -- requirements
Module: secuenciador_pila

Interface
REQ-001 The block SHALL have parameter ANCHO, default 4, giving the microaddress width.
REQ-002 The block SHALL have parameter PROF, default 4, giving the subroutine stack depth (>=2).
REQ-003 The block SHALL have port reloj, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port cc, input, 1 bit: condition code; the condition is true when cc=0.
REQ-006 The block SHALL have port microinstruccion, input, 3 bits: opcode.
REQ-007 The block SHALL have ports liga, vect and vmap, input, ANCHO each: link, interrupt-vector and mapping addresses.
REQ-008 The block SHALL have ports pl, map_hab and vect_hab, output, 1 bit each: active-low source enables, registered.
REQ-009 The block SHALL have port estado_presente, output, ANCHO: current microaddress, registered.
REQ-010 The block SHALL have ports pila_llena and pila_vacia, output, 1 bit each: stack status, combinational from the stack pointer.
REQ-011 The block SHALL have port error_pila, output, 1 bit: sticky stack overflow/underflow flag.

Function
REQ-012 All registered outputs SHALL update one reloj edge after the opcode is sampled; sig = estado_presente+1, modulo 2^ANCHO (wraps to 0).
REQ-013 Opcode 000 SHALL be continue: next = sig; pl=1, map_hab=1, vect_hab=1.
REQ-014 Opcode 001 SHALL be conditional jump: if cc=0, next = liga with pl=0; else continue.
REQ-015 Opcode 010 SHALL be map: next = vmap with map_hab=0, regardless of cc.
REQ-016 Opcode 011 SHALL be conditional vector: if cc=0, next = vect with vect_hab=0; else continue.
REQ-017 Opcode 100 SHALL be conditional call: if cc=0 and the stack is not full, push sig, next = liga and pl=0; else continue.
REQ-018 Opcode 101 SHALL be return: if the stack is not empty, pop, next = top of stack; enables all 1.
REQ-019 Opcode 110 SHALL be load counter: contador <= liga; next = sig.
REQ-020 Opcode 111 SHALL be loop: if contador!=0, contador decrements and next = liga with pl=0; if contador=0, continue.
REQ-021 For each opcode, any enable not named in REQ-013 to REQ-020 SHALL be 1; at most one enable is 0 in any cycle.
REQ-022 A call while the stack is full SHALL act as continue, leave the stack unchanged and set error_pila.
REQ-023 A return while the stack is empty SHALL act as continue and set error_pila.
REQ-024 pila_llena SHALL be 1 when PROF entries are held; pila_vacia SHALL be 1 when 0 entries are held.

Reset
REQ-025 When reset=1 at an edge, estado_presente SHALL become 0 and pl, map_hab and vect_hab SHALL become 1.
REQ-026 When reset=1 at an edge, the stack pointer SHALL become empty, contador SHALL become 0 and error_pila SHALL become 0.
REQ-027 Reset SHALL override every opcode, including a push or pop in the same cycle.
REQ-028 Stack contents SHALL need no reset.

Configuration
REQ-029 With macro SECUENCIADOR_CONTADOR_EN defined, the block SHALL include an ANCHO-bit contador and opcodes 110/111 SHALL behave per REQ-019 and REQ-020.
REQ-030 Without SECUENCIADOR_CONTADOR_EN, no counter SHALL be built and opcodes 110 and 111 SHALL behave as continue.

Structure
REQ-031 Opcode constants (OP_CONT, OP_SALTO, OP_MAPA, OP_VECT, OP_LLAMA, OP_RET, OP_CARGA, OP_CICLO) SHALL live in package secuenciador_pkg.
REQ-032 The stack SHALL be sub-module pila_lifo (parameters ANCHO and PROF; push, pop, dato, tope, llena, vacia), where a push and pop never occur in the same cycle.

Verification
REQ-033 Reset then opcode 000 for 17 cycles (ANCHO=4) SHALL give estado_presente 1,2,...,15,0,1, with all enables 1.
REQ-034 At estado=3, opcode 001 with liga=9: cc=0 SHALL give next 9 and pl=0; cc=1 SHALL give next 4 and pl=1.
REQ-035 At estado=2, opcode 100 with cc=0 and liga=8, then opcode 101, SHALL give estado 8, then 3, with pila_vacia 0 then 1.
REQ-036 Five calls (PROF=4) SHALL give pila_llena=1 after the 4th call; the 5th call SHALL continue and set error_pila=1, and reset SHALL clear it.
REQ-037 Return on an empty stack SHALL give next = sig and error_pila=1.
REQ-038 With SECUENCIADOR_CONTADOR_EN, opcode 110 with liga=2 followed by opcode 111 with liga=5 SHALL jump to 5 exactly twice, then continue; without the macro, both opcodes SHALL continue.
